id_hazard_controller: RTL and testbench

//  Pipeline sequencer for the decode stage of the 5-stage MIPS core. It tracks
//  the destination registers of the instructions in EX and MEM and raises stalls
//  for RAW hazards and load-use hazards. It flushes wrong-path instructions on a

---
 rtl/id_hazard_controller.sv | 166 ++++++++++++++++
 tb/tb_id_hazard_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_controller.sv
// Decode-stage pipeline sequencer for the 5-stage MIPS core.
// It keeps a small scoreboard of the instructions in EX and MEM. From that it
// raises load-use / RAW stalls, flushes wrong-path work on a taken branch, and
// freezes every pipeline register while data memory is busy.
module id_hazard_controller #(
  parameter bit FORWARDING = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic [4:0]       i_id_dest,
  input  logic             i_id_regwrite,
  input  logic             i_id_memread,
  input  logic             i_mem_br_taken,
  input  logic             i_mem_busy,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_bubble,
  output logic             o_ex_flush,
  output logic             o_pipe_freeze,
  output logic             o_hazard_stall,
  output logic [CNT_W-1:0] o_stall_cycles
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FREEZE = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic       r_ex_valid;
  logic       r_ex_regwrite;
  logic       r_ex_memread;
  logic [4:0] r_ex_dest;
  logic       r_mem_valid;
  logic       r_mem_regwrite;
  logic       r_mem_memread;
  logic [4:0] r_mem_dest;

  logic [CNT_W-1:0] r_stall_cycles;

  logic w_ex_match;
  logic w_mem_match;
  logic w_hazard;
  logic w_pc_write;
  logic w_if_id_write;
  logic w_if_id_flush;
  logic w_id_ex_bubble;
  logic w_ex_flush;
  logic w_pipe_freeze;
  logic w_hazard_stall;

  // Compare the ID source registers against the EX and MEM destinations.
  // A bubble or a write to $zero never produces a dependency.
  always_comb begin
    w_ex_match  = r_ex_valid & r_ex_regwrite & (r_ex_dest != 5'd0) &
                  ((r_ex_dest == i_id_rs) | (i_id_uses_rt & (r_ex_dest == i_id_rt)));
    w_mem_match = r_mem_valid & r_mem_regwrite & (r_mem_dest != 5'd0) &
                  ((r_mem_dest == i_id_rs) | (i_id_uses_rt & (r_mem_dest == i_id_rt)));
    if (FORWARDING)
      w_hazard = i_id_valid & w_ex_match & r_ex_memread;
    else
      w_hazard = i_id_valid & (w_ex_match | w_mem_match);
  end

  // Next state and pipeline controls; busy memory beats a taken branch, which
  // beats a hazard. Leaving FREEZE, that same cycle behaves exactly like RUN.
  always_comb begin
    w_state_next   = r_state;
    w_pc_write     = 1'b1;
    w_if_id_write  = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_bubble = 1'b0;
    w_ex_flush     = 1'b0;
    w_pipe_freeze  = 1'b0;
    w_hazard_stall = 1'b0;

    case (r_state)
      ST_RUN:    if (i_mem_busy)  w_state_next = ST_FREEZE;
      ST_FREEZE: if (!i_mem_busy) w_state_next = ST_RUN;
      default:   w_state_next = ST_RUN;
    endcase

    if (i_mem_busy) begin
      w_pipe_freeze = 1'b1;
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
    end else if (i_mem_br_taken) begin
      w_if_id_flush  = 1'b1;
      w_id_ex_bubble = 1'b1;
      w_ex_flush     = 1'b1;
    end else if (w_hazard) begin
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_id_ex_bubble = 1'b1;
      w_hazard_stall = 1'b1;
    end

    if (!rst_n) begin
      w_state_next   = ST_RUN;
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_if_id_flush  = 1'b0;
      w_id_ex_bubble = 1'b1;
      w_ex_flush     = 1'b0;
      w_pipe_freeze  = 1'b0;
      w_hazard_stall = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_RUN;
    else
      r_state <= w_state_next;
  end

  // Shift ID into the EX/MEM scoreboard unless frozen; a bubble enters as invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid     <= 1'b0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_ex_dest      <= 5'd0;
      r_mem_valid    <= 1'b0;
      r_mem_regwrite <= 1'b0;
      r_mem_memread  <= 1'b0;
      r_mem_dest     <= 5'd0;
    end else if (!w_pipe_freeze) begin
      r_mem_valid    <= r_ex_valid;
      r_mem_regwrite <= r_ex_regwrite;
      r_mem_memread  <= r_ex_memread;
      r_mem_dest     <= r_ex_dest;
      r_ex_valid     <= i_id_valid & ~w_id_ex_bubble;
      r_ex_regwrite  <= i_id_regwrite;
      r_ex_memread   <= i_id_memread;
      r_ex_dest      <= i_id_dest;
    end
  end

  // Saturating count of cycles lost to hazard stalls or memory freezes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cycles <= '0;
    else if ((w_hazard_stall | w_pipe_freeze) && (r_stall_cycles != '1))
      r_stall_cycles <= r_stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign o_pc_write     = w_pc_write;
  assign o_if_id_write  = w_if_id_write;
  assign o_if_id_flush  = w_if_id_flush;
  assign o_id_ex_bubble = w_id_ex_bubble;
  assign o_ex_flush     = w_ex_flush;
  assign o_pipe_freeze  = w_pipe_freeze;
  assign o_hazard_stall = w_hazard_stall;
  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_id_hazard_controller.sv
// Bench for id_hazard_controller: a forwarding instance and a non-forwarding
// instance share one stimulus stream; expected control vectors are queued when
// an instruction is presented and compared on the following falling edge.
module tb_id_hazard_controller;

  localparam int CNT_F = 4;
  localparam int CNT_N = 6;

  // Control vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_flush, pipe_freeze, hazard_stall}
  localparam logic [6:0] NORM  = 7'b1100000;
  localparam logic [6:0] STALL = 7'b0001001;
  localparam logic [6:0] FLUSH = 7'b1111100;
  localparam logic [6:0] FRZ   = 7'b0000010;
  localparam logic [6:0] RST   = 7'b0001000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       idValid, idUsesRt, idRegwrite, idMemread, brTaken, memBusy;
  logic [4:0] idRs, idRt, idDest;

  logic pcF, ifidF, flushF, bubF, exfF, frzF, stlF;
  logic pcN, ifidN, flushN, bubN, exfN, frzN, stlN;
  logic [CNT_F-1:0] cntF;
  logic [CNT_N-1:0] cntN;

  int checks = 0;
  int errors = 0;

  logic [13:0] expQ[$];
  string       tagQ[$];

  always #5 clk = ~clk;

  id_hazard_controller #(.FORWARDING(1'b1), .CNT_W(CNT_F)) uFwd (
    .clk(clk), .rst_n(rst_n),
    .i_id_valid(idValid), .i_id_rs(idRs), .i_id_rt(idRt), .i_id_uses_rt(idUsesRt),
    .i_id_dest(idDest), .i_id_regwrite(idRegwrite), .i_id_memread(idMemread),
    .i_mem_br_taken(brTaken), .i_mem_busy(memBusy),
    .o_pc_write(pcF), .o_if_id_write(ifidF), .o_if_id_flush(flushF),
    .o_id_ex_bubble(bubF), .o_ex_flush(exfF), .o_pipe_freeze(frzF),
    .o_hazard_stall(stlF), .o_stall_cycles(cntF)
  );

  id_hazard_controller #(.FORWARDING(1'b0), .CNT_W(CNT_N)) uNoFwd (
    .clk(clk), .rst_n(rst_n),
    .i_id_valid(idValid), .i_id_rs(idRs), .i_id_rt(idRt), .i_id_uses_rt(idUsesRt),
    .i_id_dest(idDest), .i_id_regwrite(idRegwrite), .i_id_memread(idMemread),
    .i_mem_br_taken(brTaken), .i_mem_busy(memBusy),
    .o_pc_write(pcN), .o_if_id_write(ifidN), .o_if_id_flush(flushN),
    .o_id_ex_bubble(bubN), .o_ex_flush(exfN), .o_pipe_freeze(frzN),
    .o_hazard_stall(stlN), .o_stall_cycles(cntN)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Present one ID-stage instruction for one cycle and queue its expected controls.
  task automatic applyStimulus(input string tag, input logic valid,
                               input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                               input logic [4:0] dest, input logic rw, input logic mr,
                               input logic br, input logic busy,
                               input logic [6:0] expF, input logic [6:0] expN);
    @(posedge clk);
    #1;
    idValid = valid; idRs = rs; idRt = rt; idUsesRt = usesRt;
    idDest = dest; idRegwrite = rw; idMemread = mr; brTaken = br; memBusy = busy;
    expQ.push_back({expF, expN});
    tagQ.push_back(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, NORM);
  endtask

  // Scoreboard drain: compare both instances against the queued expectation.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      logic [13:0] e;
      string       t;
      e = expQ.pop_front();
      t = tagQ.pop_front();
      checkOutput({t, "_fwd"}, {25'd0, pcF, ifidF, flushF, bubF, exfF, frzF, stlF}, {25'd0, e[13:7]});
      checkOutput({t, "_nofwd"}, {25'd0, pcN, ifidN, flushN, bubN, exfN, frzN, stlN}, {25'd0, e[6:0]});
    end
  end

  task automatic checkCounters(input string tag, input int expF, input int expN);
    @(negedge clk);
    #1;
    checkOutput({tag, "_cntF"}, 32'(cntF), 32'(expF));
    checkOutput({tag, "_cntN"}, 32'(cntN), 32'(expN));
  endtask

  initial begin
    rst_n = 1'b0;
    idValid = 0; idRs = 0; idRt = 0; idUsesRt = 0; idDest = 0;
    idRegwrite = 0; idMemread = 0; brTaken = 0; memBusy = 0;
    #3;
    checkOutput("rst_fwd", {25'd0, pcF, ifidF, flushF, bubF, exfF, frzF, stlF}, {25'd0, RST});
    checkOutput("rst_nofwd", {25'd0, pcN, ifidN, flushN, bubN, exfN, frzN, stlN}, {25'd0, RST});
    checkOutput("rst_cntF", 32'(cntF), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // lw $t0 ; add $t1,$t0,$t2
    applyStimulus("lu_lw",   1, 5'd29, 5'd8,  0, 5'd8, 1, 1, 0, 0, NORM, NORM);
    applyStimulus("lu_add1", 1, 5'd8,  5'd10, 1, 5'd9, 1, 0, 0, 0, STALL, STALL);
    applyStimulus("lu_add2", 1, 5'd8,  5'd10, 1, 5'd9, 1, 0, 0, 0, NORM, STALL);
    applyStimulus("lu_add3", 1, 5'd8,  5'd10, 1, 5'd9, 1, 0, 0, 0, NORM, NORM);
    idle("i1"); idle("i2");
    checkCounters("lu", 1, 2);

    // add $t0 ; sub $t3,$t0,$t1
    applyStimulus("raw_add",  1, 5'd17, 5'd18, 1, 5'd8,  1, 0, 0, 0, NORM, NORM);
    applyStimulus("raw_sub1", 1, 5'd8,  5'd9,  1, 5'd11, 1, 0, 0, 0, NORM, STALL);
    applyStimulus("raw_sub2", 1, 5'd8,  5'd9,  1, 5'd11, 1, 0, 0, 0, NORM, STALL);
    applyStimulus("raw_sub3", 1, 5'd8,  5'd9,  1, 5'd11, 1, 0, 0, 0, NORM, NORM);
    idle("i3"); idle("i4");
    checkCounters("raw", 1, 4);

    // lw $0 then a reader of $0: never a hazard
    applyStimulus("z_lw",  1, 5'd29, 5'd0, 0, 5'd0, 1, 1, 0, 0, NORM, NORM);
    applyStimulus("z_add", 1, 5'd0,  5'd0, 1, 5'd9, 1, 0, 0, 0, NORM, NORM);
    idle("i5"); idle("i6");

    // lw $t0 ; sw $t0 -> rt dependency
    applyStimulus("sw_lw",  1, 5'd29, 5'd8, 0, 5'd8, 1, 1, 0, 0, NORM, NORM);
    applyStimulus("sw_sw1", 1, 5'd29, 5'd8, 1, 5'd0, 0, 0, 0, 0, STALL, STALL);
    applyStimulus("sw_sw2", 1, 5'd29, 5'd8, 1, 5'd0, 0, 0, 0, 0, NORM, STALL);
    idle("i7"); idle("i8");

    // lw $t0 ; addi with rt=$t0 but rt not read -> no stall
    applyStimulus("nr_lw",   1, 5'd29, 5'd8, 0, 5'd8, 1, 1, 0, 0, NORM, NORM);
    applyStimulus("nr_addi", 1, 5'd29, 5'd8, 0, 5'd8, 1, 0, 0, 0, NORM, NORM);
    idle("i9"); idle("i10");
    checkCounters("sw", 2, 6);

    // taken branch beats a load-use hazard
    applyStimulus("br_lw",  1, 5'd29, 5'd8,  0, 5'd8, 1, 1, 0, 0, NORM, NORM);
    applyStimulus("br_add", 1, 5'd8,  5'd10, 1, 5'd9, 1, 0, 1, 0, FLUSH, FLUSH);
    idle("i11"); idle("i12");
    checkCounters("br", 2, 6);

    // memory busy for 3 cycles during a load-use hazard
    applyStimulus("mb_lw",   1, 5'd29, 5'd8,  0, 5'd8, 1, 1, 0, 0, NORM, NORM);
    for (int i = 0; i < 3; i++)
      applyStimulus("mb_frz", 1, 5'd8, 5'd10, 1, 5'd9, 1, 0, 0, 1, FRZ, FRZ);
    applyStimulus("mb_stl1", 1, 5'd8, 5'd10, 1, 5'd9, 1, 0, 0, 0, STALL, STALL);
    applyStimulus("mb_stl2", 1, 5'd8, 5'd10, 1, 5'd9, 1, 0, 0, 0, NORM, STALL);
    idle("i13"); idle("i14");
    checkCounters("mb", 6, 11);

    // reset pulsed in the middle of a freeze
    applyStimulus("mr_lw",  1, 5'd29, 5'd8,  0, 5'd8, 1, 1, 0, 0, NORM, NORM);
    applyStimulus("mr_frz", 1, 5'd8,  5'd10, 1, 5'd9, 1, 0, 0, 1, FRZ, FRZ);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_outF", {25'd0, pcF, ifidF, flushF, bubF, exfF, frzF, stlF}, {25'd0, RST});
    checkOutput("mr_outN", {25'd0, pcN, ifidN, flushN, bubN, exfN, frzN, stlN}, {25'd0, RST});
    checkOutput("mr_cntF", 32'(cntF), 32'd0);
    checkOutput("mr_cntN", 32'(cntN), 32'd0);
    memBusy = 1'b0;
    idValid = 1'b0;
    #1;
    rst_n = 1'b1;
    applyStimulus("mr_add", 1, 5'd8, 5'd10, 1, 5'd9, 1, 0, 0, 0, NORM, NORM);
    idle("i15");
    checkCounters("mr", 0, 0);

    // 2^CNT_F + 5 freeze cycles: the narrow counter must stick at all-ones
    for (int i = 0; i < (1 << CNT_F) + 5; i++)
      applyStimulus("sat_frz", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, FRZ, FRZ);
    idle("i16");
    checkCounters("sat", (1 << CNT_F) - 1, (1 << CNT_F) + 5);
    idle("i17");
    checkCounters("sat2", (1 << CNT_F) - 1, (1 << CNT_F) + 5);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
